// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings, flag indices and issue packet type
//
// Purpose: the control encodings the issue stage passes to the ALU, the bit
// positions inside the 3-bit flag vector {carry,zero,sign}, and the packet
// layout held in the issue FIFO.
// Ports: none (package).
package alu_pkg;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_AND  = 5'b00001;
   localparam logic [4:0] ALU_XOR  = 5'b00010;
   localparam logic [4:0] ALU_SHL  = 5'b00011;
   localparam logic [4:0] ALU_DIFF = 5'b10000;

   localparam int FLAG_CARRY = 2;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_SIGN  = 0;

   typedef struct packed {
      logic [31:0] rs;
      logic [31:0] rt;
      logic [4:0]  ctrl;
      logic [4:0]  rd;
   } issue_pkt_t;

   localparam int PKT_W = $bits(issue_pkt_t);

endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - occupancy-tracked circular FIFO for the issue stage
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of two, >= 2). Pointers wrap
// naturally at DEPTH; full/empty come from the entry count, so equal
// pointers are never ambiguous.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write push_data at the tail (caller guarantees !full)
//   pop                drop the head entry (caller guarantees !empty)
//   head_data          current head entry (undefined content when empty)
//   count              number of valid entries, 0..DEPTH
//   empty, full        derived from count
module issue_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage needs no reset: an entry is only ever read after it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - buffered ALU issue stage with registered result
//
// Purpose: queues decoded operand packets, presents the FIFO head to an
// external combinational ALU, and captures the ALU result into a single
// output register with a valid/ready writeback handshake.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready                 decode handshake
//   in_rs, in_rt, in_ctrl, in_rd      incoming packet fields
//   alu_a, alu_b, alu_ctrl            ALU operand/control drive (zero when empty)
//   alu_result, alu_flags             ALU response, {carry,zero,sign}
//   out_valid/out_ready               writeback handshake
//   out_result, out_flags, out_rd     registered result packet
//   status_flags                      flags of the last completed writeback
//   occupancy                         FIFO entry count
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_rs,
   input  logic [31:0]              in_rt,
   input  logic [4:0]               in_ctrl,
   input  logic [4:0]               in_rd,
   output logic [31:0]              alu_a,
   output logic [31:0]              alu_b,
   output logic [4:0]               alu_ctrl,
   input  logic [31:0]              alu_result,
   input  logic [2:0]               alu_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [2:0]               out_flags,
   output logic [4:0]               out_rd,
   output logic [2:0]               status_flags,
   output logic [$clog2(DEPTH):0]   occupancy
);

   issue_pkt_t push_pkt;
   issue_pkt_t fifo_head;
   issue_pkt_t head_pkt;
   logic       fifo_empty;
   logic       fifo_full;
   logic       push;
   logic       fire;
   logic       ready_en;

   assign push_pkt = '{rs: in_rs, rt: in_rt, ctrl: in_ctrl, rd: in_rd};

   // ready_en holds in_ready low during reset and for the cycle of release,
   // so in_ready only ever depends on registered state.
   assign in_ready = ready_en && !fifo_full;
   assign push     = in_valid && in_ready;

   // Fire when the output register is empty or is being drained this cycle.
   assign fire     = !fifo_empty && (!out_valid || out_ready);

   issue_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_pkt),
      .pop       (fire),
      .head_data (fifo_head),
      .count     (occupancy),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Stale storage must not reach the ALU when nothing is queued.
   assign head_pkt = fifo_empty ? '0 : fifo_head;
   assign alu_a    = head_pkt.rs;
   assign alu_b    = head_pkt.rt;
   assign alu_ctrl = head_pkt.ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en     <= 1'b0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_flags    <= '0;
         out_rd       <= '0;
         status_flags <= '0;
      end else begin
         ready_en <= 1'b1;
         if (fire) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_flags  <= alu_flags;
            out_rd     <= head_pkt.rd;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) begin
            status_flags <= out_flags;
         end
      end
   end

endmodule
